period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//  Measures the period and high time of a slow square wave in system clock cycles.
//  Typical sources: divided-clock ticks, button or LCD-strobe waveforms.
//  Sits on the 50 MHz clk domain and feeds the LCD formatting logic.
//  Emits a one-cycle strobe per completed period and flags an input that has stopped.
// PARAMETERS
//  N       30        width of count, period and high_time
//  TIMEOUT 50000000  cycles without a rising edge before timeout (1 s at 50 MHz); TIMEOUT < 2^N
//  DEB     4         debounce hold length in cycles; used only with PERIOD_METER_DEBOUNCE_EN
// PORTS
//  clk        in   1  system clock, rising edge
//  rs         in   1  asynchronous, active-high reset
//  sig_in     in   1  asynchronous square wave to measure
//  period     out  N  last complete period in clk cycles
//  high_time  out  N  high portion of that same period in clk cycles
//  meas_valid out  1  one-cycle strobe: period and high_time updated this cycle
//  timeout    out  1  sticky; input stopped toggling
// BEHAVIOUR
//  Reset (rs=1, async): all outputs = 0; sync flops = 0; cnt = 0; hi_lat = 0; state = ARM.
//  Input path:
//   - 2-flop synchronizer gives s.
//   - Edge detect against s_d (previous s): rise = s & ~s_d; fall = ~s & s_d.
//   - Synchronizer latency is 2 cycles and shifts both edges equally, so measured values are unaffected.
//  FSM:
//   - ARM: wait for s == 0, then go to WAIT_RISE. This blocks a false rise when sig_in is high at reset release.
//   - WAIT_RISE: on rise, cnt <= 1 and go to MEASURE.
//   - MEASURE, every cycle: cnt <= cnt + 1.
//   - MEASURE on fall: hi_lat <= cnt.
//   - MEASURE on rise: period <= cnt; high_time <= hi_lat; meas_valid <= 1; timeout <= 0; cnt <= 1.
//   - MEASURE, no rise and cnt == TIMEOUT: timeout <= 1; cnt <= 0; go to WAIT_RISE. meas_valid stays 0.
//  Counting rule: rises detected T cycles apart give period = T exactly. A fall H cycles after the rise gives high_time = H.
//  Output timing:
//   - Outputs are registered and update in the cycle after the detected rise.
//   - meas_valid is high for exactly 1 cycle per completed period.
//   - The first rise after ARM or timeout only starts a measurement; it never strobes.
//  Rise and timeout in the same cycle: the rise wins (valid measurement, timeout cleared).
//  Width rules:
//   - cnt never exceeds TIMEOUT, so it never wraps.
//   - period and high_time hold their values between strobes and through a timeout.
//  Reset mid-measurement: immediate async clear. hi_lat is discarded; the restart goes through ARM.
// CONFIGURATION
//  PERIOD_METER_DEBOUNCE_EN defined:
//   - s is replaced by a filtered level that changes only after the synchronized input holds the new value for DEB consecutive cycles.
//   - This adds DEB cycles of latency to both edges; period and high_time are unchanged for clean input.
//   - Pulses shorter than DEB cycles are ignored.
//  PERIOD_METER_DEBOUNCE_EN undefined:
//   - s comes straight from the synchronizer; no filter logic; DEB is unused.
// TESTING
//  1. sig_in period 100 cycles, high 30 -> from the 2nd rise on, meas_valid every 100 cycles with period=100, high_time=30.
//  2. sig_in high at reset release, then low 50 / high 50 -> no strobe until ARM, then a full period; first strobe period=100, high_time=50.
//  3. TIMEOUT=1000; toggle, then hold sig_in constant -> timeout=1 exactly 1000 cycles after the last rise; no meas_valid; period holds.
//  4. Continues from 3: restart toggling at period 200 -> timeout clears at the 2nd rise, together with meas_valid, period=200.
//  5. Assert rs for 3 cycles mid-high-phase -> all outputs 0 immediately; after release, first strobe only after ARM plus one full period.
//  6. PERIOD_METER_DEBOUNCE_EN, DEB=4, period 100 with a 2-cycle low glitch mid-high -> glitch ignored; period=100, high_time=50.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow square wave in clk cycles.
// Emits a one-cycle meas_valid strobe per completed period and a sticky timeout
// flag when no rising edge arrives within TIMEOUT cycles.
// Optional input glitch filter: define PERIOD_METER_DEBOUNCE_EN (hold length DEB).
module period_meter #(
  parameter int unsigned N       = 30,
  parameter int unsigned TIMEOUT = 50000000,
  parameter int unsigned DEB     = 4
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         meas_valid,
  output logic         timeout
);

  typedef enum logic [1:0] {
    ARM,
    WAIT_RISE,
    MEASURE
  } state_t;

  localparam logic [N-1:0] TO_VAL = N'(TIMEOUT);
  localparam logic [N-1:0] ONE    = N'(1);

  logic s1;
  logic s2;
  logic s;
  logic s_d;
  logic rise;
  logic fall;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

`ifdef PERIOD_METER_DEBOUNCE_EN
  localparam int unsigned DW    = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int unsigned PRIME = DEB + 2;

  logic [DW-1:0] db_cnt;
  logic          s_f;

  // Level filter: follow s2 only after it has held a new value for DEB cycles.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      db_cnt <= '0;
      s_f    <= 1'b0;
    end else if (s2 == s_f) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEB - 1)) begin
      s_f    <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  assign s = s_f;
`else
  localparam int unsigned PRIME = 2;

  assign s = s2;
`endif

  // The input path flops come out of reset at 0, so s reads low before it
  // carries a real sample. ARM only trusts s after PRIME cycles have passed;
  // otherwise an input held high through reset would look like a rising edge.
  localparam int unsigned PW = $clog2(PRIME + 1);

  logic [PW-1:0] prime_cnt;
  logic          primed;

  assign primed = (prime_cnt == PW'(PRIME));

  // Counts cycles since reset release until the input path holds real data.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      prime_cnt <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + PW'(1);
    end
  end

  // Previous filtered level for edge detection.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  state_t       state;
  state_t       state_n;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_n;
  logic [N-1:0] hi_lat;
  logic [N-1:0] hi_lat_n;
  logic [N-1:0] period_n;
  logic [N-1:0] high_time_n;
  logic         meas_valid_n;
  logic         timeout_n;

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state      <= ARM;
      cnt        <= '0;
      hi_lat     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi_lat     <= hi_lat_n;
      period     <= period_n;
      high_time  <= high_time_n;
      meas_valid <= meas_valid_n;
      timeout    <= timeout_n;
    end
  end

  // Next-state and datapath: a rise in MEASURE takes priority over timeout.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hi_lat_n     = hi_lat;
    period_n     = period;
    high_time_n  = high_time;
    meas_valid_n = 1'b0;
    timeout_n    = timeout;
    unique case (state)
      ARM: begin
        if (primed && !s) begin
          state_n = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          cnt_n   = ONE;
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        cnt_n = cnt + ONE;
        if (fall) begin
          hi_lat_n = cnt;
        end
        if (rise) begin
          period_n     = cnt;
          high_time_n  = hi_lat;
          meas_valid_n = 1'b1;
          timeout_n    = 1'b0;
          cnt_n        = ONE;
        end else if (cnt == TO_VAL) begin
          timeout_n = 1'b1;
          cnt_n     = '0;
          state_n   = WAIT_RISE;
        end
      end
      default: begin
        state_n = ARM;
      end
    endcase
  end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: cycle-level model on sampled sig_in plus literal
// strobe checks for each directed scenario.
module tb_period_meter;

  localparam int unsigned N   = 30;
  localparam int unsigned TO  = 1000;
  localparam int unsigned DEB = 4;
  localparam int unsigned LAT = 2;

  logic         clk;
  logic         rs;
  logic         sig_in;
  logic [N-1:0] period;
  logic [N-1:0] high_time;
  logic         meas_valid;
  logic         timeout;

  period_meter #(
    .N      (N),
    .TIMEOUT(TO),
    .DEB    (DEB)
  ) dut (
    .clk       (clk),
    .rs        (rs),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned p;
    int unsigned h;
    bit          v;
    bit          t;
  } exp_t;

  typedef struct {
    int unsigned p;
    int unsigned h;
  } sb_t;

  int   checks;
  int   errors;
  bit   done;
  bit   model_on;
  exp_t exp_q[$];
  exp_t cur;
  sb_t  sq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input bit v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic square(input int hi, input int lo, input int n);
    repeat (n) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic chk_strobes(input string name, input int cnt, input int p, input int h);
    chk({name, "_count"}, sq.size(), cnt);
    if (sq.size() > 0) begin
      chk({name, "_period"}, sq[0].p, p);
      chk({name, "_high"}, sq[0].h, h);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_period"}, period, 0);
    chk({name, "_high"}, high_time, 0);
    chk({name, "_valid"}, meas_valid, 0);
    chk({name, "_timeout"}, timeout, 0);
  endtask

  initial begin
    clk      = 1'b0;
    rs       = 1'b1;
    sig_in   = 1'b1;
    done     = 1'b0;
    checks   = 0;
    errors   = 0;
`ifdef PERIOD_METER_DEBOUNCE_EN
    model_on = 1'b0;
`else
    model_on = 1'b1;
`endif
    fork
      // Model: rises/falls of the sampled input, expected outputs LAT edges later.
      begin : model
        exp_t        z;
        exp_t        ex;
        bit          prev;
        bit          meas;
        bit          x;
        int unsigned e;
        int unsigned last_rise;
        int unsigned hi;
        z    = '{p: 0, h: 0, v: 1'b0, t: 1'b0};
        ex   = z;
        prev = 1'b1;
        meas = 1'b0;
        e    = 0;
        last_rise = 0;
        hi   = 0;
        while (!done) begin
          @(posedge clk or posedge rs);
          if (rs) begin
            ex    = z;
            prev  = 1'b1;
            meas  = 1'b0;
            e     = 0;
            hi    = 0;
            exp_q = {z, z};
            cur   = z;
          end else begin
            e++;
            x    = sig_in;
            ex.v = 1'b0;
            if (meas) begin
              if (!x && prev) hi = e - last_rise;
              if (x && !prev) begin
                ex.p = e - last_rise;
                ex.h = hi;
                ex.v = 1'b1;
                ex.t = 1'b0;
                last_rise = e;
              end else if (e - last_rise == TO) begin
                ex.t = 1'b1;
                meas = 1'b0;
              end
            end else if (x && !prev) begin
              meas = 1'b1;
              last_rise = e;
            end
            prev = x;
            exp_q.push_back(ex);
            if (exp_q.size() > LAT) cur = exp_q.pop_front();
          end
        end
      end
      // Compare: DUT against model every cycle out of reset; log strobes.
      begin : compare
        while (!done) begin
          @(negedge clk);
          if (!done && !rs) begin
            if (meas_valid) sq.push_back('{p: 32'(period), h: 32'(high_time)});
            if (model_on) begin
              checks++;
              if (32'(period) != cur.p || 32'(high_time) != cur.h ||
                  meas_valid != cur.v || timeout != cur.t) begin
                errors++;
                $display("FAIL cycle_model @%0t: got p=%0d h=%0d v=%0d t=%0d expected p=%0d h=%0d v=%0d t=%0d",
                         $time, period, high_time, meas_valid, timeout,
                         cur.p, cur.h, cur.v, cur.t);
              end
            end
          end
        end
      end
      // Directed stimulus.
      begin : stim
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rs = 1'b0;
        @(posedge clk);
        #1;

        // High at reset release, then low 50 / high 50.
        hold(1'b1, 40);
        hold(1'b0, 50);
        square(50, 50, 3);
        chk_strobes("arm_start", 2, 100, 50);

        // Period 100, high 30 from a timed-out state.
        hold(1'b0, 1100);
        chk("pre_t1_timeout", timeout, 1);
        sq.delete();
        square(30, 70, 5);
        chk_strobes("p100_h30", 4, 100, 30);
        if (sq.size() == 4) begin
          chk("p100_h30_last_period", sq[3].p, 100);
          chk("p100_h30_last_high", sq[3].h, 30);
        end

        // Input stops: timeout sets, period holds, no strobe.
        sq.delete();
        hold(1'b0, 1100);
        chk("stop_timeout", timeout, 1);
        chk("stop_period_hold", period, 100);
        chk("stop_high_hold", high_time, 30);
        chk("stop_no_strobe", sq.size(), 0);

        // Restart at period 200: timeout clears with the first strobe.
        square(100, 100, 3);
        chk_strobes("restart_p200", 2, 200, 100);
        chk("restart_timeout", timeout, 0);

        // Period exactly TIMEOUT: rise wins.
        hold(1'b0, 1100);
        sq.delete();
        square(400, 600, 3);
        chk_strobes("tie_p1000", 2, 1000, 400);
        chk("tie_timeout", timeout, 0);

        // Period TIMEOUT+1: every period times out, no strobes.
        hold(1'b0, 1100);
        sq.delete();
        square(400, 601, 3);
        chk("over_count", sq.size(), 0);
        chk("over_timeout", timeout, 1);
        chk("over_period_hold", period, 1000);

        // Reset mid-high-phase.
        hold(1'b1, 20);
        rs = 1'b1;
        #1;
        chk_zero("mid_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rs = 1'b0;
        @(posedge clk);
        #1;
        sq.delete();
        hold(1'b1, 30);
        hold(1'b0, 50);
        square(50, 50, 3);
        chk_strobes("after_reset", 2, 100, 50);

`ifdef PERIOD_METER_DEBOUNCE_EN
        // 2-cycle low glitch inside the high phase is filtered out.
        hold(1'b0, 1100);
        sq.delete();
        repeat (3) begin
          hold(1'b1, 24);
          hold(1'b0, 2);
          hold(1'b1, 24);
          hold(1'b0, 50);
        end
        chk_strobes("glitch", 2, 100, 50);
`endif
        repeat (4) @(posedge clk);
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
